// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT unsigned adder sums into one saturating
// frame total. The total is presented on a registered valid/ready output.
// After the result is taken, the block starts collecting the next frame.
// ACC_W must be greater than IN_W, and COUNT must be at least 1.
module sum_accumulator #(
   parameter int IN_W  = 5,
   parameter int ACC_W = 12,
   parameter int COUNT = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_sum,
   input  logic                       clear,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_acc,
   output logic [$clog2(COUNT+1)-1:0] out_count,
   output logic                       overflow
);

   localparam int CNT_W = $clog2(COUNT + 1);

   // Count value that, once one more sample is accepted, completes the frame.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   // Saturation value of the accumulator.
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   typedef enum logic {
      ACCUM,
      HOLD
   } state_t;

   state_t             state;
   logic               accept;
   logic               last_sample;
   logic [ACC_W:0]     acc_sum;

   // A sample is taken only while collecting and while the ready flag is raised.
   // The ready flag stays low during the first cycle after reset.
   assign accept      = (state == ACCUM) && in_valid && in_ready;
   assign last_sample = (out_count == LAST_CNT);

   // The sum carries one extra bit. A set top bit means the frame total no longer fits.
   assign acc_sum = {1'b0, out_acc} + (ACC_W + 1)'(in_sum);

   // These registers hold the frame state. clear has priority over both the
   // sample handshake and the result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         overflow  <= 1'b0;
      end else if (clear) begin
         state     <= ACCUM;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         overflow  <= 1'b0;
      end else begin
         unique case (state)
            ACCUM: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (acc_sum[ACC_W]) begin
                     out_acc  <= ACC_MAX;
                     overflow <= 1'b1;
                  end else begin
                     out_acc <= acc_sum[ACC_W-1:0];
                  end
                  out_count <= out_count + 1'b1;
                  if (last_sample) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_acc   <= '0;
                  out_count <= '0;
                  overflow  <= 1'b0;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator. It drives two instances with the same inputs.
// One instance uses the default 12-bit total. The other uses a 7-bit total so
// that saturation occurs within a frame of eight samples.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_sum;
   logic        clear;
   logic        out_ready;

   logic        rdyA, validA, ovfA;
   logic [11:0] accA;
   logic [3:0]  cntA;
   logic        rdyB, validB, ovfB;
   logic [6:0]  accB;
   logic [3:0]  cntB;

   int total = 0;
   int bad   = 0;

   // Reference model. It stores the true (unsaturated) sum of the frame.
   // Saturation is applied only when the expected outputs are produced.
   bit mHold;
   bit mRdy;
   int mCount;
   int mSum;

   typedef struct {
      bit clr;
      bit iv;
      int sum;
      bit ordy;
      bit eRdy;
      bit eVal;
      int eCnt;
      int eAcc;
   } vec_t;

   vec_t vecs[13];

   sum_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyA),
      .in_sum(in_sum), .clear(clear), .out_valid(validA), .out_ready(out_ready),
      .out_acc(accA), .out_count(cntA), .overflow(ovfA)
   );

   sum_accumulator #(.ACC_W(7)) dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyB),
      .in_sum(in_sum), .clear(clear), .out_valid(validB), .out_ready(out_ready),
      .out_acc(accB), .out_count(cntB), .overflow(ovfB)
   );

   always #5 clk = ~clk;

   // Watchdog: stops the run if it exceeds its time bound.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "[TB] timeout");
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int satAcc(input int s, input int maxv);
      return (s > maxv) ? maxv : s;
   endfunction

   task automatic modelReset();
      mHold  = 1'b0;
      mRdy   = 1'b0;
      mCount = 0;
      mSum   = 0;
   endtask

   // One clock edge of the model. Inputs are the values present at the edge.
   task automatic modelStep(input bit clr, input bit iv, input int sum, input bit ordy);
      if (clr) begin
         mHold = 1'b0; mCount = 0; mSum = 0;
      end else if (!mHold) begin
         if (iv && mRdy) begin
            mSum   += sum;
            mCount += 1;
            if (mCount == 8) mHold = 1'b1;
         end
      end else if (ordy) begin
         mHold = 1'b0; mCount = 0; mSum = 0;
      end
      mRdy = !mHold;
   endtask

   task automatic checkOutput(input string tag);
      cmp({tag, " in_ready"},   rdyA,   mRdy);
      cmp({tag, " out_valid"},  validA, mHold);
      cmp({tag, " out_count"},  cntA,   mCount);
      cmp({tag, " out_acc"},    accA,   satAcc(mSum, 4095));
      cmp({tag, " overflow"},   ovfA,   mSum > 4095);
      cmp({tag, " in_ready7"},  rdyB,   mRdy);
      cmp({tag, " out_valid7"}, validB, mHold);
      cmp({tag, " out_count7"}, cntB,   mCount);
      cmp({tag, " out_acc7"},   accB,   satAcc(mSum, 127));
      cmp({tag, " overflow7"},  ovfB,   mSum > 127);
   endtask

   // Drives one cycle of inputs, steps the model at the edge, and checks on the falling edge.
   task automatic applyStimulus(input bit clr, input bit iv, input int sum, input bit ordy,
                                input string tag);
      clear     = clr;
      in_valid  = iv;
      in_sum    = 5'(sum);
      out_ready = ordy;
      @(posedge clk);
      modelStep(clr, iv, sum, ordy);
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; clear = 1'b0; out_ready = 1'b0;
      modelReset();

      vecs[0]  = '{0, 0,  0, 0, 1, 0, 0,  0};
      vecs[1]  = '{0, 1, 10, 0, 1, 0, 1, 10};
      vecs[2]  = '{0, 1, 10, 0, 1, 0, 2, 20};
      vecs[3]  = '{0, 1, 10, 0, 1, 0, 3, 30};
      vecs[4]  = '{0, 1, 10, 0, 1, 0, 4, 40};
      vecs[5]  = '{0, 1, 10, 0, 1, 0, 5, 50};
      vecs[6]  = '{0, 1, 10, 0, 1, 0, 6, 60};
      vecs[7]  = '{0, 1, 10, 0, 1, 0, 7, 70};
      vecs[8]  = '{0, 1, 10, 0, 0, 1, 8, 80};
      vecs[9]  = '{0, 1, 10, 0, 0, 1, 8, 80};
      vecs[10] = '{0, 1, 10, 1, 1, 0, 0,  0};
      vecs[11] = '{0, 1,  3, 0, 1, 0, 1,  3};
      vecs[12] = '{1, 1,  9, 0, 1, 0, 0,  0};

      // Reset values while reset is held.
      @(negedge clk);
      cmp("reset in_ready", rdyA, 0);
      cmp("reset out_valid", validA, 0);
      cmp("reset out_acc", accA, 0);
      cmp("reset out_count", cntA, 0);
      cmp("reset overflow", ovfA, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven phase: a back-to-back frame of eight 10s, backpressure, handshake, then clear.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].clr, vecs[i].iv, vecs[i].sum, vecs[i].ordy, $sformatf("vec%0d", i));
         cmp($sformatf("vec%0d tbl in_ready", i), rdyA, vecs[i].eRdy);
         cmp($sformatf("vec%0d tbl out_valid", i), validA, vecs[i].eVal);
         cmp($sformatf("vec%0d tbl out_count", i), cntA, vecs[i].eCnt);
         cmp($sformatf("vec%0d tbl out_acc", i), accA, vecs[i].eAcc);
         cmp($sformatf("vec%0d tbl out_acc7", i), accB, vecs[i].eAcc);
      end

      // Gapped frame of 30s. The 7-bit instance saturates on the fifth sample.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, (i % 2) == 0, 30, 0, "gap");
         if (i == 6) begin
            cmp("gap acc7 before sat", accB, 120);
            cmp("gap ovf7 before sat", ovfB, 0);
         end
         if (i == 8) begin
            cmp("gap acc7 at sat", accB, 127);
            cmp("gap ovf7 at sat", ovfB, 1);
         end
      end
      cmp("gap out_valid", validA, 1);
      cmp("gap out_acc", accA, 240);
      cmp("gap out_count", cntA, 8);
      cmp("gap overflow", ovfA, 0);
      cmp("gap out_acc7", accB, 127);
      cmp("gap overflow7", ovfB, 1);

      // Result handshake, then a frame of ones. Overflow must not carry over.
      applyStimulus(0, 0, 0, 1, "hs1");
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, "ones");
      cmp("ones out_acc7", accB, 8);
      cmp("ones overflow7", ovfB, 0);
      cmp("ones out_acc", accA, 8);

      // Backpressure while samples are offered. Outputs must stay stable and nothing is consumed.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 7, 0, "bp");
         cmp("bp in_ready", rdyA, 0);
         cmp("bp out_acc", accA, 8);
         cmp("bp out_count", cntA, 8);
      end
      applyStimulus(0, 1, 7, 1, "bp hs");
      cmp("bp hs out_valid", validA, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, "bp next");
      cmp("bp next out_acc", accA, 8);
      cmp("bp next out_valid", validA, 1);

      // A clear arrives after three accepts. The sample offered with the clear is dropped.
      applyStimulus(0, 0, 0, 1, "hs2");
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 10, 0, "pre clr");
      cmp("pre clr out_count", cntA, 3);
      applyStimulus(1, 1, 10, 0, "clr");
      cmp("clr out_count", cntA, 0);
      cmp("clr out_acc", accA, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 5, 0, "post clr");
      cmp("post clr out_acc", accA, 40);
      cmp("post clr out_valid", validA, 1);

      // Asynchronous reset is asserted mid-HOLD, between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async out_valid", validA, 0);
      cmp("async out_acc", accA, 0);
      cmp("async out_count", cntA, 0);
      cmp("async overflow", ovfA, 0);
      cmp("async out_acc7", accB, 0);
      cmp("async overflow7", ovfB, 0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20 && !mHold; i++) applyStimulus(0, 1, 10, 0, "post rst");
      cmp("post rst out_valid", validA, 1);
      cmp("post rst out_acc", accA, 80);
      cmp("post rst out_count", cntA, 8);

      // Randomized traffic checked against the model.
      applyStimulus(0, 0, 0, 1, "hs3");
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 31)), $urandom_range(0, 2) != 0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 4-bit adder. Consumes the adder's 5-bit sum output, one sample per valid/ready handshake.
- Accumulates COUNT samples into a wide saturating register. Presents the frame total on a registered valid/ready output, then starts the next frame.
- Used to collect adder results over a frame for checking and reporting.

Parameters:
- IN_W, 5, width of the incoming sum (4-bit operands plus carry).
- ACC_W, 12, accumulator/result width; must be greater than IN_W.
- COUNT, 8, samples per frame; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  IN_W  unsigned sample from the adder.
- clear  input  1  synchronous frame abort.
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  frame total, saturated.
- out_count  output  $clog2(COUNT+1)  samples accepted in the current frame.
- overflow  output  1  saturation occurred in the frame being reported or accumulated.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous) clears all state:
  - state=ACCUM; out_valid=0, out_acc=0, out_count=0, overflow=0.
  - in_ready=1 from the first clock edge after reset release.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Accept = in_valid & in_ready, sampled on the rising edge.
  - On accept, compute acc_next = acc + zero-extended in_sum in ACC_W+1 bits.
  - If bit ACC_W of acc_next is set, acc saturates to 2^ACC_W-1 and overflow sets (sticky within the frame). Otherwise acc = acc_next[ACC_W-1:0].
  - out_count increments on each accept.
- Frame completion:
  - On the accept that brings the count to COUNT, go to HOLD next cycle.
  - In HOLD: out_valid=1, out_acc = final total (including that sample), out_count=COUNT.
  - Latency is one cycle from the last accept to out_valid.
- HOLD:
  - in_ready=0; in_valid is ignored and no sample is consumed.
  - out_acc, out_count and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to ACCUM next cycle with acc=0, out_count=0, overflow=0, out_valid=0.
  - No zero-bubble overlap: a new sample is accepted no earlier than the cycle after the handshake.
- out_acc in ACCUM shows the running total. It is informational only; valid solely when out_valid=1.
- clear:
  - Highest synchronous priority; overrides accept and the output handshake in the same cycle.
  - Next state is ACCUM with acc=0, out_count=0, overflow=0, out_valid=0.
  - A sample presented in the same cycle as clear is dropped. in_ready stays as the current state dictates.
  - A result in HOLD is discarded.
- COUNT=1: every accept goes straight to HOLD.
- Async reset mid-frame or mid-HOLD: outputs go to reset values immediately, without waiting for a clock edge. The partial frame is lost.
- Arithmetic is unsigned only. in_sum values up to 2^IN_W-1 are legal.

Test Plan:
- Reset release, 8 back-to-back samples in_sum=10 (5+5) -> out_valid one cycle after the 8th accept; out_acc=80, out_count=8, overflow=0.
- 8 samples in_sum=30 (15+15), with in_valid gapped every other cycle -> out_acc=240, overflow=0; out_count steps 1..8 only on accept cycles.
- Override ACC_W=7, 8 samples of 30 -> saturation on the 5th sample (120+30>127); out_acc=127, overflow=1; next frame of 8 samples of 1 -> out_acc=8, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with in_sum=7 -> in_ready=0, out_acc/out_count stable; on out_ready=1, one-cycle handshake; next frame excludes the ignored samples (8 samples of 1 -> 8).
- Pulse clear after 3 accepts of 10, with in_valid high in the same cycle -> out_count=0 next cycle, that sample dropped; next 8 samples of 5 give out_acc=40.
- Assert rst_n=0 mid-HOLD, asynchronously between clock edges -> out_valid, out_acc, out_count and overflow go to 0 before the next clock edge; after release, a fresh 8×10 frame gives 80.
